// File: rtl/multicycle_main_control_if.sv
// Control bus between the multi-cycle main control FSM and the datapath.
// The controller takes the master side; the datapath and memory take the slave side.
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       ir_write;
  logic [1:0] pc_source;
  logic [1:0] ALUop;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic       reg_dst;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, pc_source, ALUop, alu_src_a, alu_src_b, reg_write,
           reg_dst, illegal_op, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, pc_source, ALUop, alu_src_a, alu_src_b, reg_write,
           reg_dst, illegal_op, state
  );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Moore decode of the
// state register, with ir_write/pc_write in FETCH qualified by mem_ready and
// illegal_op in DECODE qualified by the opcode.
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic                          clk,
  input  logic                          reset,
  multicycle_main_control_if.master     bus
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDI_EX = 4'd10,
    ADDI_WB = 4'd11
  } state_t;

  state_t     state_q, state_d;

  logic       pc_write_d, pc_write_cond_d, i_or_d_d, mem_read_d, mem_write_d;
  logic       mem_to_reg_d, ir_write_d, alu_src_a_d, reg_write_d, reg_dst_d;
  logic       illegal_op_d;
  logic [1:0] pc_source_d, alu_op_d, alu_src_b_d;

  // State register; reset returns to FETCH and abandons any instruction.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values of its inputs, independent of evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state and output decode; reset forces every control output low.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    pc_write_d      = 1'b0;
    pc_write_cond_d = 1'b0;
    i_or_d_d        = 1'b0;
    mem_read_d      = 1'b0;
    mem_write_d     = 1'b0;
    mem_to_reg_d    = 1'b0;
    ir_write_d      = 1'b0;
    pc_source_d     = 2'b00;
    alu_op_d        = 2'b00;
    alu_src_a_d     = 1'b0;
    alu_src_b_d     = 2'b00;
    reg_write_d     = 1'b0;
    reg_dst_d       = 1'b0;
    illegal_op_d    = 1'b0;

    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          mem_read_d  = 1'b1;
          alu_src_b_d = 2'b01;
          if (bus.mem_ready) begin
            ir_write_d = 1'b1;
            pc_write_d = 1'b1;
            state_d    = DECODE;
          end
        end
        DECODE: begin
          alu_src_b_d = 2'b11;
          if (bus.opcode == OP_LW || bus.opcode == OP_SW) state_d = MEMADR;
          else if (bus.opcode == OP_RTYPE)                state_d = EXEC;
          else if (bus.opcode == OP_BEQ)                  state_d = BRANCH;
          else if (bus.opcode == OP_J)                    state_d = JUMP;
          else if (bus.opcode == OP_ADDI)                 state_d = ADDI_EX;
          else begin
            illegal_op_d = 1'b1;
            state_d      = FETCH;
          end
        end
        MEMADR: begin
          alu_src_a_d = 1'b1;
          alu_src_b_d = 2'b10;
          // Opcode is re-sampled here; anything but lw/sw drops the instruction.
          if (bus.opcode == OP_LW)      state_d = MEMRD;
          else if (bus.opcode == OP_SW) state_d = MEMWR;
          else                          state_d = FETCH;
        end
        MEMRD: begin
          mem_read_d = 1'b1;
          i_or_d_d   = 1'b1;
          if (bus.mem_ready) state_d = MEMWB;
        end
        MEMWB: begin
          reg_write_d  = 1'b1;
          mem_to_reg_d = 1'b1;
          state_d      = FETCH;
        end
        MEMWR: begin
          mem_write_d = 1'b1;
          i_or_d_d    = 1'b1;
          if (bus.mem_ready) state_d = FETCH;
        end
        EXEC: begin
          alu_src_a_d = 1'b1;
          alu_op_d    = 2'b10;
          state_d     = RWB;
        end
        RWB: begin
          reg_write_d = 1'b1;
          reg_dst_d   = 1'b1;
          state_d     = FETCH;
        end
        BRANCH: begin
          alu_src_a_d     = 1'b1;
          alu_op_d        = 2'b01;
          pc_write_cond_d = 1'b1;
          pc_source_d     = 2'b01;
          state_d         = FETCH;
        end
        JUMP: begin
          pc_write_d  = 1'b1;
          pc_source_d = 2'b10;
          state_d     = FETCH;
        end
        ADDI_EX: begin
          alu_src_a_d = 1'b1;
          alu_src_b_d = 2'b10;
          state_d     = ADDI_WB;
        end
        ADDI_WB: begin
          reg_write_d = 1'b1;
          state_d     = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.pc_write      = pc_write_d;
  assign bus.pc_write_cond = pc_write_cond_d;
  assign bus.i_or_d        = i_or_d_d;
  assign bus.mem_read      = mem_read_d;
  assign bus.mem_write     = mem_write_d;
  assign bus.mem_to_reg    = mem_to_reg_d;
  assign bus.ir_write      = ir_write_d;
  assign bus.pc_source     = pc_source_d;
  assign bus.ALUop         = alu_op_d;
  assign bus.alu_src_a     = alu_src_a_d;
  assign bus.alu_src_b     = alu_src_b_d;
  assign bus.reg_write     = reg_write_d;
  assign bus.reg_dst       = reg_dst_d;
  assign bus.illegal_op    = illegal_op_d;
  // The debug state reads FETCH while reset is held, even before the first edge.
  assign bus.state         = reset ? FETCH : state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Bench for multicycle_main_control: directed test-plan scenarios followed by
// random instruction streams, checked against an instruction-level model.
module tb_multicycle_main_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       illegal_op;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  multicycle_main_control_if bus ();

  multicycle_main_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ctrl_t dut_ctrl;
  assign dut_ctrl = '{bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                      bus.mem_write, bus.mem_to_reg, bus.ir_write, bus.pc_source,
                      bus.ALUop, bus.alu_src_a, bus.alu_src_b, bus.reg_write,
                      bus.reg_dst, bus.illegal_op};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
  endfunction

  // Control outputs the specification's state table calls for.
  function automatic ctrl_t exp_ctrl(input int st, input logic mr, input logic rst,
                                     input logic [5:0] op);
    ctrl_t c;
    c = '0;
    if (!rst) begin
      case (st)
        0:  begin c.mem_read = 1; c.alu_src_b = 2'b01;
                  if (mr) begin c.ir_write = 1; c.pc_write = 1; end end
        1:  begin c.alu_src_b = 2'b11; c.illegal_op = !is_legal(op); end
        2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        3:  begin c.mem_read = 1; c.i_or_d = 1; end
        4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
        5:  begin c.mem_write = 1; c.i_or_d = 1; end
        6:  begin c.alu_src_a = 1; c.aluop = 2'b10; end
        7:  begin c.reg_write = 1; c.reg_dst = 1; end
        8:  begin c.alu_src_a = 1; c.aluop = 2'b01; c.pc_write_cond = 1; c.pc_source = 2'b01; end
        9:  begin c.pc_write = 1; c.pc_source = 2'b10; end
        10: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
        11: begin c.reg_write = 1; end
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // One clock: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic cycle(input int exp_state, input logic [5:0] op, input logic mr,
                       input logic rst);
    ctrl_t e;
    reset         = rst;
    bus.opcode    = op;
    bus.mem_ready = mr;
    @(negedge clk);
    e = exp_ctrl(exp_state, mr, rst, op);
    check("state", 32'(bus.state), 32'(exp_state));
    check("ctrl", 32'(dut_ctrl), 32'(e));
    check("invariant", {30'd0, bus.ALUop == 2'b11, bus.mem_read & bus.mem_write}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Whole instruction as the model sees it: fetch with fw wait cycles, decode,
  // then the opcode's path with mw wait cycles in its memory state. Outside
  // DECODE/MEMADR the opcode is replaced by noise when scramble is set.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input logic scramble);
    int path[$];
    int mem_state;
    logic [5:0] noise;
    for (int i = 0; i < fw; i++) begin
      noise = scramble ? 6'($urandom) : op;
      cycle(0, noise, 1'b0, 1'b0);
    end
    noise = scramble ? 6'($urandom) : op;
    cycle(0, noise, 1'b1, 1'b0);
    cycle(1, op, 1'($urandom), 1'b0);
    mem_state = -1;
    case (op)
      OP_LW:    begin path = '{2, 3, 4}; mem_state = 3; end
      OP_SW:    begin path = '{2, 5};    mem_state = 5; end
      OP_RTYPE: path = '{6, 7};
      OP_BEQ:   path = '{8};
      OP_J:     path = '{9};
      OP_ADDI:  path = '{10, 11};
      default:  path = '{};
    endcase
    foreach (path[k]) begin
      if (path[k] == mem_state) begin
        for (int i = 0; i < mw; i++) begin
          noise = scramble ? 6'($urandom) : op;
          cycle(path[k], noise, 1'b0, 1'b0);
        end
        noise = scramble ? 6'($urandom) : op;
        cycle(path[k], noise, 1'b1, 1'b0);
      end else begin
        noise = (scramble && path[k] != 2) ? 6'($urandom) : op;
        cycle(path[k], noise, 1'($urandom), 1'b0);
      end
    end
  endtask

  initial begin
    logic [5:0] ops [6];
    logic [5:0] op;
    int         sel;
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

    // Reset held for three cycles with a load presented.
    repeat (3) cycle(0, OP_LW, 1'b1, 1'b1);
    // lw: 0,1,2,3,4 then back to FETCH.
    run_instr(OP_LW, 0, 0, 1'b0);
    // R-type: 0,1,6,7.
    run_instr(OP_RTYPE, 0, 0, 1'b0);
    // beq then j back to back.
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_J, 0, 0, 1'b0);
    // sw with two fetch stalls and three write stalls: nine cycles.
    run_instr(OP_SW, 2, 3, 1'b0);
    // Undefined opcode: one-cycle illegal_op pulse in DECODE.
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0);

    // Reset while MEMRD is stalled; the write-back must never happen.
    cycle(0, OP_LW, 1'b1, 1'b0);
    cycle(1, OP_LW, 1'b1, 1'b0);
    cycle(2, OP_LW, 1'b1, 1'b0);
    cycle(3, OP_LW, 1'b0, 1'b0);
    cycle(0, OP_LW, 1'b0, 1'b1);
    run_instr(OP_RTYPE, 1, 0, 1'b0);

    // Random instruction stream with random stalls and opcode noise.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 6);
      if (sel < 6) op = ops[sel];
      else begin
        op = 6'b111111;
        for (int t = 0; t < 8; t++) begin
          op = 6'($urandom);
          if (!is_legal(op)) break;
        end
        if (is_legal(op)) op = 6'b111111;
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
